// File: rtl/cpu_pkg.sv
// Shared datapath constants and the MEM/WB pipeline bundle used by the
// write-back stage and its pipeline latch.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // "do" is a reserved word, so the memory read value travels as dout.
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] dout;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

  function automatic logic [DATA_W-1:0] wbSelect(input memwb_t s);
    return s.m2reg ? s.dout : s.r;
  endfunction

endpackage

// File: rtl/wb_regwrite_memwb_reg.sv
// MEM/WB pipeline latch: captures the MEM bundle each edge, holds on stall
// and inserts a cleared bubble on flush.
module memwb_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall_i,
  input  logic   flush_i,
  input  memwb_t mem_i,
  output memwb_t wb_o
);

  memwb_t state_q;
  memwb_t state_d;

  // Stall wins over flush so a held instruction is never lost to a bubble.
  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      state_d = flush_i ? MEMWB_BUBBLE : mem_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEMWB_BUBBLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign wb_o = state_q;

endmodule

// File: rtl/wb_regwrite.sv
// Write-back stage: MEM/WB latch, ALU/memory result select, 32x32 register
// array commit, and two combinational read ports with write-through bypass.
module wb_regwrite
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [ADDR_W-1:0] mdestReg,
  input  logic [DATA_W-1:0] mr,
  input  logic [DATA_W-1:0] mdo,
  input  logic              wb_stall,
  input  logic              wb_flush,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic              wwreg,
  output logic [ADDR_W-1:0] wdestReg,
  output logic [DATA_W-1:0] wbData,
  output logic [31:0]       wb_count
);

  memwb_t memIn;
  memwb_t wbQ;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [31:0]       count_q;
  logic              commitEn;
  logic              bypassOk;

  assign memIn = '{wreg: mwreg, m2reg: mm2reg, dest: mdestReg, r: mr, dout: mdo};

  memwb_reg u_memwb (
    .clk     (clk),
    .rst     (rst),
    .stall_i (wb_stall),
    .flush_i (wb_flush),
    .mem_i   (memIn),
    .wb_o    (wbQ)
  );

  assign wwreg    = wbQ.wreg;
  assign wdestReg = wbQ.dest;
  assign wbData   = wbSelect(wbQ);

  // A held (stalled) instruction must neither commit nor be forwarded.
  assign bypassOk = wbQ.wreg && !wb_stall;
  assign commitEn = bypassOk && (wbQ.dest != REG_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commitEn) begin
      rf_q[wbQ.dest] <= wbData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (commitEn) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign wb_count = count_q;

  always_comb begin
    qa = rf_q[rna];
    if (rna == REG_ZERO) begin
      qa = '0;
    end else if (bypassOk && (rna == wbQ.dest)) begin
      qa = wbData;
    end
  end

  always_comb begin
    qb = rf_q[rnb];
    if (rnb == REG_ZERO) begin
      qb = '0;
    end else if (bypassOk && (rnb == wbQ.dest)) begin
      qb = wbData;
    end
  end

endmodule

// File: doc/wb_regwrite.md
Name: wb_regwrite

Overview:
- Write-back end of the register-file interface: the writer that pairs with the ID-stage register read.
- Holds the MEM/WB pipeline register, selects ALU result vs memory data, and commits to the 32x32 register array.
- Exposes two combinational read ports with write-through bypass, so ID reads see the value being written this cycle.
- Sits between the MEM stage and the ID-stage decode.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register address width
NREGS, 32, number of architectural registers (must equal 2**ADDR_W)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
mwreg  input  1  MEM-stage register-write enable
mm2reg  input  1  MEM-stage select: 1 = memory data, 0 = ALU result
mdestReg  input  ADDR_W  MEM-stage destination register number
mr  input  DATA_W  MEM-stage ALU result
mdo  input  DATA_W  MEM-stage data-memory read value
wb_stall  input  1  hold MEM/WB register contents (no new capture, no commit)
wb_flush  input  1  capture a bubble into MEM/WB (wwreg forced 0)
rna  input  ADDR_W  read port A address (rs)
rnb  input  ADDR_W  read port B address (rt)
qa  output  DATA_W  read port A data
qb  output  DATA_W  read port B data
wwreg  output  1  MEM/WB write-enable (registered)
wdestReg  output  ADDR_W  MEM/WB destination (registered, for forwarding)
wbData  output  DATA_W  write-back value: wm2reg ? wdo : wr
wb_count  output  32  count of committed register writes

Behaviour:
- Reset (async, rst=1): all NREGS entries = 0; MEM/WB fields wwreg, wm2reg, wdestReg, wr, wdo = 0; wb_count = 0. Outputs during reset: wwreg=0, wdestReg=0, wbData=0, qa/qb=0.
- MEM/WB capture on each rising clk:
  - wb_stall=0, wb_flush=0: latch mwreg, mm2reg, mdestReg, mr, mdo.
  - wb_flush=1 (and wb_stall=0): latch wwreg=0; other fields are don't-care but are cleared to 0.
  - wb_stall=1: hold every field. Stall has priority over flush.
- Commit on rising clk when wwreg=1, wdestReg!=0 and wb_stall=0:
  - rF[wdestReg] <= wbData; wb_count <= wb_count+1 (wraps at 2^32-1 -> 0).
  - Commit and MEM/WB capture happen on the same edge; the commit uses the pre-edge MEM/WB contents.
- Register 0: never written. A write targeting r0 neither commits nor increments wb_count. qa/qb for address 0 always return 0.
- Timing: MEM inputs sampled at edge E1 -> wbData valid after E1 -> array updated at E2. Total latency is 2 edges from MEM presentation to array.
- Read ports (combinational), for each port independently:
  - addr==0 -> 0;
  - else if wwreg=1, addr==wdestReg and wb_stall=0 -> wbData (bypass);
  - else rF[addr].
- During a stall, bypass is disabled; reads return the array value.
- Both ports may read the same address. Both may bypass simultaneously.
- Reset asserted mid-operation discards any pending MEM/WB write; nothing is committed.

Decomposition:
- Shared package cpu_pkg: DATA_W/ADDR_W constants, the REG_ZERO address constant, and the MEM/WB bundle typedef {wreg, m2reg, dest, r, do}.
- One natural sub-module: memwb_reg (MEM/WB pipeline latch with stall/flush). The array, mux, bypass and counter remain in wb_regwrite.

Test Plan:
- Reset, then read all 32 addresses -> qa=qb=0, wb_count=0, wwreg=0.
- mwreg=1, mm2reg=0, mdestReg=5, mr=0xDEADBEEF at E1; rna=5 between E1 and E2 -> qa=0xDEADBEEF via bypass; after E2, rF[5]=0xDEADBEEF and wb_count=1.
- mwreg=1, mm2reg=1, mdestReg=0, mdo=0x1234 -> wbData=0x1234, but qa(rna=0)=0 always and wb_count is unchanged.
- Write r7=0x11 with wb_stall=1 held for 3 cycles -> r7 unchanged and no bypass; deassert stall -> commit on the next edge, wb_count+1.
- wb_flush=1 with mwreg=1, mdestReg=9, mr=0x55 -> wwreg=0 after the edge, r9 stays 0; with wb_stall=1 and wb_flush=1 together, the prior MEM/WB contents are held.
- Assert rst between E1 and E2 of a pending write to r3 -> r3=0, wb_count=0; back-to-back writes to r3 then r4 (rna=3, rnb=4) -> both commit in order and both bypass correctly in their cycles.
